// File: rtl/interrupt_scheduler_pkg.sv
// Shared types and constants for the interrupt scheduler: instruction width,
// the idle/NOP instruction value and the injection FSM state encoding.
package interrupt_scheduler_pkg;

    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] IRQ_NOP = 32'h0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } sched_state_t;

endpackage

// File: rtl/interrupt_scheduler_if.sv
// Bundle of the request side (per-source valid/instr/ready) and the CPU side
// (inject_en, injected instruction, pulse, status) of the interrupt scheduler.
interface interrupt_scheduler_if #(
    parameter int NUM_SRC    = 4,
    parameter int FIFO_DEPTH = 4
);
    import interrupt_scheduler_pkg::*;

    localparam int COUNT_W = $clog2(FIFO_DEPTH + 1);

    logic [NUM_SRC-1:0]         src_valid;
    logic [INSTR_W*NUM_SRC-1:0] src_instr;
    logic [NUM_SRC-1:0]         src_ready;
    logic                       inject_en;
    logic [INSTR_W-1:0]         interrupt_instruction;
    logic                       inject_pulse;
    logic [COUNT_W-1:0]         fifo_count;
    logic                       busy;

    modport master (
        output src_valid, src_instr, inject_en,
        input  src_ready, interrupt_instruction, inject_pulse, fifo_count, busy
    );

    modport slave (
        input  src_valid, src_instr, inject_en,
        output src_ready, interrupt_instruction, inject_pulse, fifo_count, busy
    );

endinterface

// File: rtl/interrupt_scheduler_isr_fifo.sv
// Synchronous FIFO holding pending interrupt instructions. dout always shows
// the head entry; push when full and pop when empty are ignored.
module isr_fifo
    import interrupt_scheduler_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = INSTR_W,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int COUNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [WIDTH-1:0]   din,
    output logic [WIDTH-1:0]   dout,
    output logic [COUNT_W-1:0] count,
    output logic               full,
    output logic               empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == COUNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array; no reset needed since count gates what is visible.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/interrupt_scheduler.sv
// Round-robin arbitration of interrupt sources into a pending FIFO, and an
// IDLE/ISSUE/GAP FSM that injects one instruction at a time with a forced
// idle gap so each injection drains the CPU pipeline before the next.
module interrupt_scheduler
    import interrupt_scheduler_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    interrupt_scheduler_if.slave  bus
);

    localparam int PTR_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int COUNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_INIT = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    logic [INSTR_W-1:0] instr_arr [NUM_SRC];
    logic [PTR_W-1:0]   rr_ptr;
    logic [NUM_SRC-1:0] grant;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W:0]     cand;
    logic               found;
    logic               push;
    logic [INSTR_W-1:0] push_data;

    logic               pop;
    logic [INSTR_W-1:0] fifo_head;
    logic [COUNT_W-1:0] fifo_count;
    logic               fifo_full;
    logic               fifo_empty;

    sched_state_t       state;
    logic [GAP_W-1:0]   gap_cnt;
    logic [INSTR_W-1:0] instr_q;
    logic               pulse_q;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign instr_arr[i] = bus.src_instr[INSTR_W*i +: INSTR_W];
    end

    // Grant the first valid source at or after rr_ptr, only while the FIFO
    // has a free slot by its registered count and reset is released.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        push_data = IRQ_NOP;
        if (reset && !fifo_full) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
                if (cand >= (PTR_W+1)'(NUM_SRC)) begin
                    cand = cand - (PTR_W+1)'(NUM_SRC);
                end
                if (!found && bus.src_valid[cand[PTR_W-1:0]]) begin
                    found                    = 1'b1;
                    grant[cand[PTR_W-1:0]]   = 1'b1;
                    grant_idx                = cand[PTR_W-1:0];
                    push_data                = instr_arr[cand[PTR_W-1:0]];
                end
            end
        end
    end

    assign push          = found;
    assign bus.src_ready = grant;

    // Advance the round-robin pointer past the source just accepted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (push) begin
            rr_ptr <= (grant_idx == PTR_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    assign pop = (state == IDLE) && !fifo_empty && bus.inject_en;

    isr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (push_data),
        .dout  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Injection FSM: one ISSUE cycle carrying the instruction, then GAP_CYCLES
    // idle cycles during which inject_en is deliberately ignored.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            gap_cnt <= '0;
            instr_q <= IRQ_NOP;
            pulse_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        instr_q <= fifo_head;
                        pulse_q <= 1'b1;
                        state   <= ISSUE;
                    end else begin
                        instr_q <= IRQ_NOP;
                        pulse_q <= 1'b0;
                    end
                end
                ISSUE: begin
                    instr_q <= IRQ_NOP;
                    pulse_q <= 1'b0;
                    if (GAP_CYCLES == 0) begin
                        state <= IDLE;
                    end else begin
                        state   <= GAP;
                        gap_cnt <= GAP_INIT;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    instr_q <= IRQ_NOP;
                    pulse_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.interrupt_instruction = instr_q;
    assign bus.inject_pulse          = pulse_q;
    assign bus.fifo_count            = fifo_count;
    assign bus.busy                  = (fifo_count != '0) || (state != IDLE);

endmodule

// File: tb/tb_interrupt_scheduler.sv
// Directed testbench for interrupt_scheduler with NUM_SRC=4, FIFO_DEPTH=4,
// GAP_CYCLES=4. Inputs change on the falling edge; outputs are read there too.
module tb_interrupt_scheduler;
    import interrupt_scheduler_pkg::*;

    localparam int NUM_SRC    = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int GAP_CYCLES = 4;
    localparam int PERIOD     = GAP_CYCLES + 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fails  = 0;

    interrupt_scheduler_if #(.NUM_SRC(NUM_SRC), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

    interrupt_scheduler #(
        .NUM_SRC    (NUM_SRC),
        .FIFO_DEPTH (FIFO_DEPTH),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 10 ns clock.
    always #5 clock = ~clock;

    // Hard stop in case the run ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic set_instr(input int src, input logic [31:0] value);
        bus.src_instr[src*32 +: 32] = value;
    endtask

    task automatic do_reset();
        reset         = 1'b0;
        bus.src_valid = '0;
        bus.inject_en = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        bus.src_instr = '0;
        set_instr(0, 32'hDEAD_0001);
        set_instr(1, 32'hDEAD_0002);
        bus.src_valid = 4'b0011;
        bus.inject_en = 1'b1;
        reset         = 1'b0;
        @(negedge clock);
        n_checks++; if (bus.src_ready !== 4'b0000) begin n_fails++; $display("[TB] FAIL rst_ready: got %b expected 0000", bus.src_ready); end
        n_checks++; if (bus.interrupt_instruction !== 32'h0) begin n_fails++; $display("[TB] FAIL rst_instr: got %h expected 0", bus.interrupt_instruction); end
        n_checks++; if (bus.inject_pulse !== 1'b0) begin n_fails++; $display("[TB] FAIL rst_pulse: got %b expected 0", bus.inject_pulse); end
        n_checks++; if (bus.fifo_count !== 3'd0) begin n_fails++; $display("[TB] FAIL rst_count: got %0d expected 0", bus.fifo_count); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fails++; $display("[TB] FAIL rst_busy: got %b expected 0", bus.busy); end
        reset = 1'b1;
        #1;
        n_checks++; if (bus.src_ready !== 4'b0001) begin n_fails++; $display("[TB] FAIL rst_first_grant: got %b expected 0001", bus.src_ready); end
        @(negedge clock);
        bus.src_valid = 4'b0010;
        #1;
        n_checks++; if (bus.src_ready !== 4'b0010) begin n_fails++; $display("[TB] FAIL rst_second_grant: got %b expected 0010", bus.src_ready); end
        @(negedge clock);
        bus.src_valid = 4'b0000;
        n_checks++; if (bus.inject_pulse !== 1'b1 || bus.interrupt_instruction !== 32'hDEAD_0001) begin n_fails++; $display("[TB] FAIL rst_pre_issue: got pulse %b instr %h expected 1 dead0001", bus.inject_pulse, bus.interrupt_instruction); end
        n_checks++; if (bus.fifo_count !== 3'd1) begin n_fails++; $display("[TB] FAIL rst_pre_count: got %0d expected 1", bus.fifo_count); end
        // Reset while ISSUE is on the output: everything must clear at once.
        reset = 1'b0;
        #1;
        n_checks++; if (bus.interrupt_instruction !== 32'h0) begin n_fails++; $display("[TB] FAIL rst_mid_instr: got %h expected 0", bus.interrupt_instruction); end
        n_checks++; if (bus.inject_pulse !== 1'b0) begin n_fails++; $display("[TB] FAIL rst_mid_pulse: got %b expected 0", bus.inject_pulse); end
        n_checks++; if (bus.fifo_count !== 3'd0) begin n_fails++; $display("[TB] FAIL rst_mid_count: got %0d expected 0", bus.fifo_count); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fails++; $display("[TB] FAIL rst_mid_busy: got %b expected 0", bus.busy); end
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_checks++; if (bus.inject_pulse !== 1'b0 || bus.fifo_count !== 3'd0 || bus.busy !== 1'b0) begin n_fails++; $display("[TB] FAIL rst_discard: got pulse %b count %0d busy %b expected 0 0 0", bus.inject_pulse, bus.fifo_count, bus.busy); end
    endtask

    task automatic test_single();
        do_reset();
        set_instr(2, 32'h1234_5678);
        bus.src_valid = 4'b0100;
        bus.inject_en = 1'b1;
        #1;
        n_checks++; if (bus.src_ready !== 4'b0100) begin n_fails++; $display("[TB] FAIL single_ready: got %b expected 0100", bus.src_ready); end
        @(negedge clock);
        bus.src_valid = 4'b0000;
        #1;
        n_checks++; if (bus.fifo_count !== 3'd1 || bus.inject_pulse !== 1'b0) begin n_fails++; $display("[TB] FAIL single_queued: got count %0d pulse %b expected 1 0", bus.fifo_count, bus.inject_pulse); end
        @(negedge clock);
        n_checks++; if (bus.interrupt_instruction !== 32'h1234_5678) begin n_fails++; $display("[TB] FAIL single_instr: got %h expected 12345678", bus.interrupt_instruction); end
        n_checks++; if (bus.inject_pulse !== 1'b1 || bus.fifo_count !== 3'd0 || bus.busy !== 1'b1) begin n_fails++; $display("[TB] FAIL single_issue_status: got pulse %b count %0d busy %b expected 1 0 1", bus.inject_pulse, bus.fifo_count, bus.busy); end
        @(negedge clock);
        n_checks++; if (bus.interrupt_instruction !== 32'h0 || bus.inject_pulse !== 1'b0) begin n_fails++; $display("[TB] FAIL single_one_cycle: got instr %h pulse %b expected 0 0", bus.interrupt_instruction, bus.inject_pulse); end
        n_checks++; if (bus.busy !== 1'b1) begin n_fails++; $display("[TB] FAIL single_gap_busy: got %b expected 1", bus.busy); end
        repeat (GAP_CYCLES) @(negedge clock);
        n_checks++; if (bus.busy !== 1'b0) begin n_fails++; $display("[TB] FAIL single_idle_again: got busy %b expected 0", bus.busy); end
    endtask

    task automatic test_round_robin();
        logic [3:0] v;
        int next_grant;
        int n_pulse;
        int last;
        do_reset();
        for (int i = 0; i < NUM_SRC; i++) set_instr(i, 32'hA000_0000 + 32'(i));
        v             = 4'b1111;
        bus.src_valid = v;
        bus.inject_en = 1'b1;
        next_grant    = 0;
        n_pulse       = 0;
        last          = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            #1;
            if (next_grant < NUM_SRC) begin
                n_checks++; if (bus.src_ready !== 4'(1 << next_grant)) begin n_fails++; $display("[TB] FAIL rr_grant%0d: got %b expected %b", next_grant, bus.src_ready, 4'(1 << next_grant)); end
                v = v & ~4'(1 << next_grant);
                next_grant++;
            end
            if (bus.inject_pulse === 1'b1) begin
                if (n_pulse < NUM_SRC) begin
                    n_checks++; if (bus.interrupt_instruction !== 32'hA000_0000 + 32'(n_pulse)) begin n_fails++; $display("[TB] FAIL rr_order%0d: got %h expected %h", n_pulse, bus.interrupt_instruction, 32'hA000_0000 + 32'(n_pulse)); end
                end
                n_checks++;
                if (n_pulse == 0) begin
                    if (cyc != 2) begin n_fails++; $display("[TB] FAIL rr_first_latency: got cycle %0d expected 2", cyc); end
                end else if (cyc - last != PERIOD) begin
                    n_fails++; $display("[TB] FAIL rr_spacing%0d: got %0d expected %0d", n_pulse, cyc - last, PERIOD);
                end
                last = cyc;
                n_pulse++;
            end
            @(negedge clock);
            bus.src_valid = v;
        end
        n_checks++; if (n_pulse != NUM_SRC) begin n_fails++; $display("[TB] FAIL rr_pulse_count: got %0d expected %0d", n_pulse, NUM_SRC); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fails++; $display("[TB] FAIL rr_end_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_full();
        logic [3:0]  v;
        logic [31:0] exp_q [6];
        int n_pulse;
        int last;
        do_reset();
        for (int i = 0; i < NUM_SRC; i++) begin
            set_instr(i, 32'hB000_0000 + 32'(i));
            exp_q[i] = 32'hB000_0000 + 32'(i);
        end
        exp_q[4]      = 32'hC000_0000;
        exp_q[5]      = 32'hC000_0001;
        v             = 4'b1111;
        bus.src_valid = v;
        for (int k = 0; k < NUM_SRC; k++) begin
            #1;
            n_checks++; if (bus.src_ready !== 4'(1 << k)) begin n_fails++; $display("[TB] FAIL full_fill%0d: got %b expected %b", k, bus.src_ready, 4'(1 << k)); end
            v = v & ~4'(1 << k);
            @(negedge clock);
            bus.src_valid = v;
        end
        set_instr(0, 32'hC000_0000);
        set_instr(1, 32'hC000_0001);
        v             = 4'b0011;
        bus.src_valid = v;
        repeat (3) begin
            #1;
            n_checks++; if (bus.src_ready !== 4'b0000) begin n_fails++; $display("[TB] FAIL full_ready: got %b expected 0000", bus.src_ready); end
            n_checks++; if (bus.fifo_count !== 3'd4 || bus.inject_pulse !== 1'b0) begin n_fails++; $display("[TB] FAIL full_hold: got count %0d pulse %b expected 4 0", bus.fifo_count, bus.inject_pulse); end
            @(negedge clock);
        end
        bus.inject_en = 1'b1;
        n_pulse       = 0;
        last          = 0;
        for (int cyc = 0; cyc < 45; cyc++) begin
            #1;
            n_checks++; if (!$onehot0(bus.src_ready)) begin n_fails++; $display("[TB] FAIL full_onehot: got %b expected at most one bit", bus.src_ready); end
            v = v & ~bus.src_ready;
            if (bus.inject_pulse === 1'b1) begin
                if (n_pulse < 6) begin
                    n_checks++; if (bus.interrupt_instruction !== exp_q[n_pulse]) begin n_fails++; $display("[TB] FAIL full_order%0d: got %h expected %h", n_pulse, bus.interrupt_instruction, exp_q[n_pulse]); end
                end
                if (n_pulse > 0) begin
                    n_checks++; if (cyc - last != PERIOD) begin n_fails++; $display("[TB] FAIL full_spacing%0d: got %0d expected %0d", n_pulse, cyc - last, PERIOD); end
                end
                last = cyc;
                n_pulse++;
            end
            @(negedge clock);
            bus.src_valid = v;
        end
        n_checks++; if (n_pulse != 6) begin n_fails++; $display("[TB] FAIL full_pulse_count: got %0d expected 6", n_pulse); end
        n_checks++; if (bus.fifo_count !== 3'd0 || bus.busy !== 1'b0) begin n_fails++; $display("[TB] FAIL full_drained: got count %0d busy %b expected 0 0", bus.fifo_count, bus.busy); end
    endtask

    task automatic test_inject_en();
        do_reset();
        set_instr(0, 32'hD000_0000);
        set_instr(1, 32'hD000_0001);
        bus.src_valid = 4'b0011;
        #1;
        n_checks++; if (bus.src_ready !== 4'b0001) begin n_fails++; $display("[TB] FAIL en_grant0: got %b expected 0001", bus.src_ready); end
        @(negedge clock);
        bus.src_valid = 4'b0010;
        #1;
        n_checks++; if (bus.src_ready !== 4'b0010) begin n_fails++; $display("[TB] FAIL en_grant1: got %b expected 0010", bus.src_ready); end
        @(negedge clock);
        bus.src_valid = 4'b0000;
        repeat (3) begin
            @(negedge clock);
            n_checks++; if (bus.inject_pulse !== 1'b0 || bus.fifo_count !== 3'd2) begin n_fails++; $display("[TB] FAIL en_hold: got pulse %b count %0d expected 0 2", bus.inject_pulse, bus.fifo_count); end
        end
        bus.inject_en = 1'b1;
        @(negedge clock);
        n_checks++; if (bus.inject_pulse !== 1'b1 || bus.interrupt_instruction !== 32'hD000_0000) begin n_fails++; $display("[TB] FAIL en_first: got pulse %b instr %h expected 1 d0000000", bus.inject_pulse, bus.interrupt_instruction); end
        // Drop inject_en during ISSUE and again during GAP; neither may matter.
        bus.inject_en = 1'b0;
        for (int d = 1; d <= PERIOD; d++) begin
            @(negedge clock);
            if (d == 1) bus.inject_en = 1'b1;
            if (d == 2) bus.inject_en = 1'b0;
            if (d == 3) bus.inject_en = 1'b1;
            if (d < PERIOD) begin
                n_checks++; if (bus.inject_pulse !== 1'b0) begin n_fails++; $display("[TB] FAIL en_gap%0d: got pulse %b expected 0", d, bus.inject_pulse); end
            end else begin
                n_checks++; if (bus.inject_pulse !== 1'b1 || bus.interrupt_instruction !== 32'hD000_0001) begin n_fails++; $display("[TB] FAIL en_second: got pulse %b instr %h expected 1 d0000001", bus.inject_pulse, bus.interrupt_instruction); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q [15];
        int fi;
        int n_pulse;
        int last;
        do_reset();
        set_instr(0, 32'hE000_0000);
        bus.src_valid = 4'b0001;
        @(negedge clock);
        bus.src_valid = 4'b0000;
        #1;
        n_checks++; if (bus.fifo_count !== 3'd1) begin n_fails++; $display("[TB] FAIL b2b_pre_count: got %0d expected 1", bus.fifo_count); end
        set_instr(1, 32'hE000_0001);
        bus.src_valid = 4'b0010;
        bus.inject_en = 1'b1;
        #1;
        n_checks++; if (bus.src_ready !== 4'b0010) begin n_fails++; $display("[TB] FAIL b2b_ready: got %b expected 0010", bus.src_ready); end
        @(negedge clock);
        n_checks++; if (bus.fifo_count !== 3'd1) begin n_fails++; $display("[TB] FAIL b2b_count: got %0d expected 1", bus.fifo_count); end
        n_checks++; if (bus.inject_pulse !== 1'b1 || bus.interrupt_instruction !== 32'hE000_0000) begin n_fails++; $display("[TB] FAIL b2b_pop: got pulse %b instr %h expected 1 e0000000", bus.inject_pulse, bus.interrupt_instruction); end
        // Stream 14 more requests from source 3 to wrap both FIFO pointers;
        // entry 5 is a zero instruction that must still pulse.
        exp_q[0] = 32'hE000_0001;
        for (int i = 0; i < 14; i++) exp_q[i+1] = (i == 5) ? 32'h0 : 32'hF000_0000 + 32'(i);
        fi = 0;
        n_pulse = 0;
        last = 0;
        set_instr(3, exp_q[1]);
        bus.src_valid = 4'b1000;
        for (int cyc = 0; cyc < 110; cyc++) begin
            #1;
            n_checks++; if ((bus.src_ready & 4'b0111) !== 4'b0000) begin n_fails++; $display("[TB] FAIL b2b_ready_src: got %b expected only bit 3", bus.src_ready); end
            if (bus.src_ready[3] === 1'b1) fi++;
            @(negedge clock);
            if (bus.inject_pulse === 1'b1) begin
                if (n_pulse < 15) begin
                    n_checks++; if (bus.interrupt_instruction !== exp_q[n_pulse]) begin n_fails++; $display("[TB] FAIL b2b_order%0d: got %h expected %h", n_pulse, bus.interrupt_instruction, exp_q[n_pulse]); end
                end
                if (n_pulse > 0) begin
                    n_checks++; if (cyc - last != PERIOD) begin n_fails++; $display("[TB] FAIL b2b_spacing%0d: got %0d expected %0d", n_pulse, cyc - last, PERIOD); end
                end
                last = cyc;
                n_pulse++;
            end
            if (fi < 14) begin
                set_instr(3, exp_q[fi+1]);
                bus.src_valid = 4'b1000;
            end else begin
                bus.src_valid = 4'b0000;
            end
        end
        n_checks++; if (n_pulse != 15) begin n_fails++; $display("[TB] FAIL b2b_pulse_count: got %0d expected 15", n_pulse); end
        n_checks++; if (bus.fifo_count !== 3'd0 || bus.busy !== 1'b0) begin n_fails++; $display("[TB] FAIL b2b_drained: got count %0d busy %b expected 0 0", bus.fifo_count, bus.busy); end
    endtask

    // Run every scenario in sequence, then report.
    initial begin
        bus.src_valid = '0;
        bus.src_instr = '0;
        bus.inject_en = 1'b0;
        $display("[TB] starting interrupt_scheduler bench");
        test_reset();
        test_single();
        test_round_robin();
        test_full();
        test_inject_en();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
